// File: rtl/abh.sv
// abh: address-bus-high stage with next-address mux, ABH/PCH/AHH registers and page-cross flag
module abh (
  input  logic       clk,
  input  logic       RST,
  input  logic       CI,
  input  logic [7:0] DB,
  input  logic [2:0] op,
  input  logic       ld_ahh,
  input  logic       ld_pc,
  input  logic       pcl_co,
  output logic [7:0] ADH,
  output logic [7:0] ABH,
  output logic [7:0] PCH,
  output logic [7:0] AHH,
  output logic       pgx
);
  logic [7:0] ci8;
  assign ci8 = {7'd0, CI};
  always_comb
    ADH = op == 3'd0 ? PCH + ci8 :
          op == 3'd1 ? 8'h01 :
          op == 3'd2 ? 8'hFF :
          op == 3'd3 ? 8'h00 :
          op == 3'd4 ? ABH + ci8 :
          op == 3'd5 ? DB + ci8 :
          op == 3'd6 ? AHH + ci8 :
                       ABH + 8'hFF + ci8;
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      ABH <= 8'hFF;
      PCH <= 8'h00;
      AHH <= 8'h00;
      pgx <= 1'b0;
    end else begin
      ABH <= ADH;
      if (ld_ahh) AHH <= DB;
      // PCH takes the pre-edge ABH, not the address being latched now
      if (ld_pc) PCH <= ABH + {7'd0, pcl_co};
      pgx <= op[2] && op != 3'd4 && CI;
    end
endmodule

// File: tb/tb_abh.sv
// tb_abh: directed and random checks of abh against an arithmetic reference model
module tb_abh;
  logic       clk, RST, CI, ld_ahh, ld_pc, pcl_co;
  logic [7:0] DB, ADH, ABH, PCH, AHH;
  logic [2:0] op;
  logic       pgx;
  int n_cmp = 0, n_err = 0;
  int m_abh, m_pch, m_ahh, m_pgx;

  abh dut (.clk(clk), .RST(RST), .CI(CI), .DB(DB), .op(op), .ld_ahh(ld_ahh),
           .ld_pc(ld_pc), .pcl_co(pcl_co), .ADH(ADH), .ABH(ABH), .PCH(PCH),
           .AHH(AHH), .pgx(pgx));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_adh(input int o, input int c, input int d);
    case (o)
      0: return (m_pch + c) % 256;
      1: return 1;
      2: return 255;
      3: return 0;
      4: return (m_abh + c) % 256;
      5: return (d + c) % 256;
      6: return (m_ahh + c) % 256;
      default: return (m_abh + 255 + c) % 256;
    endcase
  endfunction

  task automatic model_reset();
    m_abh = 255; m_pch = 0; m_ahh = 0; m_pgx = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_abh"}, ABH, m_abh);
    chk({tag, "_pch"}, PCH, m_pch);
    chk({tag, "_ahh"}, AHH, m_ahh);
    chk({tag, "_pgx"}, pgx, m_pgx);
  endtask

  task automatic step(input int o, input int c, input int d, input int la, input int lp, input int pc);
    int nadh;
    op = o[2:0]; CI = c[0]; DB = d[7:0]; ld_ahh = la[0]; ld_pc = lp[0]; pcl_co = pc[0];
    nadh = model_adh(o, c, d);
    #1 chk("adh", ADH, nadh);
    @(posedge clk);
    if (lp != 0) m_pch = (m_abh + pc) % 256;
    if (la != 0) m_ahh = d;
    m_pgx = (o >= 5 && c == 1) ? 1 : 0;
    m_abh = nadh;
    #1 chk_regs("step");
  endtask

  initial begin
    RST = 0; CI = 0; DB = 0; op = 0; ld_ahh = 0; ld_pc = 0; pcl_co = 0;
    #2 RST = 1;
    model_reset();
    #1 chk_regs("async_rst");
    op = 3'd2; ld_ahh = 1; ld_pc = 1; pcl_co = 1; DB = 8'h55;
    #1 chk("rst_adh_ff", ADH, 8'hFF);
    @(posedge clk);
    #1 chk_regs("rst_loads_ignored");
    RST = 0;
    step(3, 0, 0, 0, 0, 0);
    step(3, 0, 8'h12, 1, 0, 0);
    step(6, 1, 0, 0, 0, 0);
    chk("r029_ahh", AHH, 8'h12);
    chk("r029_abh", ABH, 8'h13);
    chk("r029_pgx", pgx, 1);
    step(2, 0, 0, 0, 0, 0);
    step(4, 1, 0, 0, 0, 0);
    chk("r030_abh", ABH, 8'h00);
    chk("r030_pgx", pgx, 0);
    step(7, 0, 0, 0, 0, 0);
    chk("wrap_back_abh", ABH, 8'hFF);
    step(5, 0, 8'h20, 0, 0, 0);
    step(7, 0, 0, 0, 0, 0);
    chk("r031a_abh", ABH, 8'h1F);
    chk("r031a_pgx", pgx, 0);
    step(5, 0, 8'h20, 0, 0, 0);
    step(7, 1, 0, 0, 0, 0);
    chk("r031b_abh", ABH, 8'h20);
    chk("r031b_pgx", pgx, 1);
    step(5, 0, 8'h34, 0, 0, 0);
    step(3, 0, 0, 0, 1, 1);
    chk("r032_pch", PCH, 8'h35);
    chk("r032_abh", ABH, 8'h00);
    step(1, 1, 0, 0, 0, 0);
    chk("r033_op1", ABH, 8'h01);
    step(2, 1, 0, 0, 0, 0);
    chk("r033_op2", ABH, 8'hFF);
    step(3, 1, 0, 0, 0, 0);
    chk("r033_op3", ABH, 8'h00);
    step(0, 1, 0, 1, 1, 0);
    ld_ahh = 1; ld_pc = 1; pcl_co = 1; DB = 8'hAA; op = 3'd5; CI = 1;
    #1 RST = 1;
    model_reset();
    #1 chk_regs("mid_rst_now");
    @(posedge clk);
    #1 chk_regs("mid_rst_edge");
    RST = 0;
    for (int i = 0; i < 300; i++)
      step($urandom_range(7), $urandom_range(1), $urandom_range(255),
           $urandom_range(1), $urandom_range(1), $urandom_range(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/abh.md
ABH -- requirements
Module: abh

Interface
REQ-001 SHALL: clk  input  1  single clock; every register updates on its rising edge.
REQ-002 SHALL: RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL: CI  input  1  carry-in from the address-bus-low stage carry output.
REQ-004 SHALL: DB  input  8  data bus.
REQ-005 SHALL: op  input  3  ABH operation select.
REQ-006 SHALL: ld_ahh  input  1  load AHH from DB.
REQ-007 SHALL: ld_pc  input  1  load PCH.
REQ-008 SHALL: pcl_co  input  1  carry-out of the PCL increment from the low stage.
REQ-009 SHALL: ADH  output  8  unregistered next address high byte.
REQ-010 SHALL: ABH  output  8  registered address bus high byte.
REQ-011 SHALL: PCH  output  8  program counter high byte.
REQ-012 SHALL: AHH  output  8  address hold high byte.
REQ-013 SHALL: pgx  output  1  registered page-cross flag.

Function
REQ-014 SHALL: ADH is combinational from op as follows.
- 000: PCH + CI (PC restore).
- 001: 8'h01 (stack page; CI ignored).
- 010: 8'hFF (vector page; CI ignored).
- 011: 8'h00 (zero page; CI ignored).
- 100: ABH + CI (stay or next).
- 101: DB + CI (absolute high byte).
- 110: AHH + CI (absolute + index).
- 111: ABH + 8'hFF + CI (backward branch).
REQ-015 SHALL: all sums are 8-bit modulo 256; carry-out is discarded (FF+1 -> 00; op 111 with CI=0 from 00 -> FF).
REQ-016 SHALL: ABH <= ADH every clock when not in reset; latency is one cycle.
REQ-017 SHALL: AHH <= DB on a clock with ld_ahh=1; otherwise AHH holds, for any number of cycles.
REQ-018 SHALL: PCH <= ABH + pcl_co (mod 256) on a clock with ld_pc=1; otherwise PCH holds.
REQ-019 SHALL: PCH is sampled from the old ABH, not from ADH, when ld_pc and the ABH update occur on the same edge.
REQ-020 SHALL: pgx <= 1 on a clock where op is 101, 110 or 111 and CI=1 (page cross or index fix-up); otherwise pgx <= 0; pgx is valid for exactly one cycle per event.
REQ-021 SHALL: ld_ahh and ld_pc asserted on the same edge both take effect independently.
REQ-022 SHALL: the block has no internal state beyond ABH, PCH, AHH and pgx.

Reset
REQ-023 SHALL: while RST=1, registers are forced asynchronously, without waiting for clk, to ABH=8'hFF, PCH=8'h00, AHH=8'h00, pgx=0.
REQ-024 SHALL: ADH remains combinational during reset (e.g. op=010 gives FF).
REQ-025 SHALL: loads are ignored on any edge where RST=1.
REQ-026 SHALL: on the first edge after RST deasserts, normal operation resumes.
REQ-027 SHALL: reset asserted mid-sequence discards pending loads with no partial update.

Verification
REQ-028 SHALL: assert RST between clock edges -> ABH=FF, PCH=00, AHH=00, pgx=0 immediately, before any edge.
REQ-029 SHALL: DB=0x12, ld_ahh=1 for one cycle, then op=110 with CI=1 -> next cycle AHH=12, ABH=13, pgx=1.
REQ-030 SHALL: ABH=0xFF, op=100, CI=1 -> ABH=00 (wrap), pgx=0.
REQ-031 SHALL: ABH=0x20, op=111, CI=0 -> ABH=1F, pgx=1 not set (CI=0); with CI=1 -> ABH=20 and pgx=1.
REQ-032 SHALL: ABH=0x34, pcl_co=1, ld_pc=1, op=011 on the same edge -> PCH=35, ABH=00.
REQ-033 SHALL: op sweep 001/010/011 with CI=1 -> ABH=01/FF/00 respectively, and the CI effect is absent.
